// File: rtl/pmu_test_sched.sv
// pmu_test_sched: runs a configured number of work/readout iterations on
// pmu_core. Each iteration pulses pmu_work_start, waits for a full
// pmu_busy high/low cycle, pulses pmu_rd_start, waits for packet_done and
// then idles for a programmable gap. Every wait phase has its own timeout,
// and an abort input ends the run early with an error code.
module pmu_test_sched #(
  parameter int LOOP_DW = 16,
  parameter int GAP_DW  = 16,
  parameter int TMO_DW  = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LOOP_DW-1:0] cfg_loop_num,
  input  logic [GAP_DW-1:0]  cfg_gap_time,
  input  logic [TMO_DW-1:0]  cfg_timeout,
  input  logic               sched_start,
  input  logic               sched_abort,
  input  logic               pmu_busy,
  input  logic               packet_done,
  output logic               pmu_work_start,
  output logic               pmu_rd_start,
  output logic               sched_busy,
  output logic               sched_done,
  output logic               sched_err,
  output logic [1:0]         err_code,
  output logic [LOOP_DW-1:0] loop_cnt
);

  // One shared timer serves both the timeout phases and the gap phase.
  localparam int TIM_DW = (TMO_DW > GAP_DW) ? TMO_DW : GAP_DW;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_START    = 3'd1;
  localparam logic [2:0] S_WAIT_BH  = 3'd2;
  localparam logic [2:0] S_WAIT_BL  = 3'd3;
  localparam logic [2:0] S_READ     = 3'd4;
  localparam logic [2:0] S_WAIT_PKT = 3'd5;
  localparam logic [2:0] S_GAP      = 3'd6;
  localparam logic [2:0] S_DONE     = 3'd7;

  logic [2:0]         r_state;
  logic [LOOP_DW-1:0] r_loop_num;
  logic [GAP_DW-1:0]  r_gap_time;
  logic [TMO_DW-1:0]  r_timeout;
  logic [TIM_DW-1:0]  r_timer;
  logic [LOOP_DW-1:0] r_loop_cnt;
  logic [1:0]         r_err_code;
  logic               r_work_start;
  logic               r_rd_start;
  logic               r_busy;
  logic               r_done;
  logic               r_err;

  logic [2:0]         w_next_state;
  logic               w_accept;
  logic               w_timer_inc;
  logic               w_cnt_inc;
  logic               w_err;
  logic [1:0]         w_err_code;
  logic               w_tmo_hit;
  logic               w_gap_end;
  logic [LOOP_DW-1:0] w_loop_inc;

  assign w_tmo_hit  = (r_timeout != '0) &&
                      (r_timer == (TIM_DW'(r_timeout) - TIM_DW'(1)));
  assign w_gap_end  = (r_timer == TIM_DW'(r_gap_time));
  assign w_loop_inc = r_loop_cnt + LOOP_DW'(1);

  // Next-state decode; an abort in any active state overrides every other transition.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_timer_inc  = 1'b0;
    w_cnt_inc    = 1'b0;
    w_err        = 1'b0;
    w_err_code   = r_err_code;
    case (r_state)
      S_IDLE: begin
        if (sched_start) begin
          w_accept     = 1'b1;
          w_next_state = (cfg_loop_num == '0) ? S_DONE : S_START;
        end
      end
      S_START: w_next_state = S_WAIT_BH;
      S_WAIT_BH: begin
        if (pmu_busy) begin
          w_next_state = S_WAIT_BL;
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = 2'd1;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_WAIT_BL: begin
        if (!pmu_busy) begin
          w_next_state = S_READ;
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = 2'd2;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_READ: w_next_state = S_WAIT_PKT;
      S_WAIT_PKT: begin
        if (packet_done) begin
          w_cnt_inc    = 1'b1;
          w_next_state = (w_loop_inc == r_loop_num) ? S_DONE : S_GAP;
        end else if (w_tmo_hit) begin
          w_err      = 1'b1;
          w_err_code = 2'd3;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_GAP: begin
        if (w_gap_end) begin
          w_next_state = S_START;
        end else begin
          w_timer_inc = 1'b1;
        end
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
    if ((r_state != S_IDLE) && sched_abort) begin
      w_err       = 1'b1;
      w_err_code  = 2'd0;
      w_cnt_inc   = 1'b0;
      w_timer_inc = 1'b0;
    end
    if (w_err) begin
      w_next_state = S_IDLE;
    end
  end

  // State register and phase timer; the timer restarts from zero whenever it is not counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next_state;
      r_timer <= w_timer_inc ? (r_timer + TIM_DW'(1)) : '0;
    end
  end

  // Configuration snapshot taken only when a run is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loop_num <= '0;
      r_gap_time <= '0;
      r_timeout  <= '0;
    end else if (w_accept) begin
      r_loop_num <= cfg_loop_num;
      r_gap_time <= cfg_gap_time;
      r_timeout  <= cfg_timeout;
    end
  end

  // Run status: iteration count and error code hold until the next accepted start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_loop_cnt <= '0;
      r_err_code <= 2'd0;
    end else if (w_accept) begin
      r_loop_cnt <= '0;
      r_err_code <= 2'd0;
    end else begin
      if (w_cnt_inc) begin
        r_loop_cnt <= w_loop_inc;
      end
      if (w_err) begin
        r_err_code <= w_err_code;
      end
    end
  end

  // Registered output pulses; an abort suppresses any pulse due on the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work_start <= 1'b0;
      r_rd_start   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_work_start <= (r_state == S_START) && !sched_abort;
      r_rd_start   <= (r_state == S_READ) && !sched_abort;
      r_busy       <= (w_next_state != S_IDLE);
      r_done       <= (r_state == S_DONE) && !sched_abort;
      r_err        <= w_err;
    end
  end

  assign pmu_work_start = r_work_start;
  assign pmu_rd_start   = r_rd_start;
  assign sched_busy     = r_busy;
  assign sched_done     = r_done;
  assign sched_err      = r_err;
  assign err_code       = r_err_code;
  assign loop_cnt       = r_loop_cnt;

endmodule

// File: tb/tb_pmu_test_sched.sv
// Self-checking bench for pmu_test_sched: a per-cycle vector table for a
// short run, then longer scenarios driven by a small pmu_core responder.
module tb_pmu_test_sched;

  localparam int LOOP_DW = 16;
  localparam int GAP_DW  = 16;
  localparam int TMO_DW  = 24;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [LOOP_DW-1:0] cfg_loop_num;
  logic [GAP_DW-1:0]  cfg_gap_time;
  logic [TMO_DW-1:0]  cfg_timeout;
  logic               sched_start;
  logic               sched_abort;
  logic               pmu_busy;
  logic               packet_done;
  logic               pmu_work_start;
  logic               pmu_rd_start;
  logic               sched_busy;
  logic               sched_done;
  logic               sched_err;
  logic [1:0]         err_code;
  logic [LOOP_DW-1:0] loop_cnt;

  // inp = {start, abort, busy, packet_done}; flg = {work_start, rd_start, busy, done, err}
  typedef struct {
    logic [3:0]  inp;
    logic [4:0]  flg;
    logic [1:0]  ec;
    logic [15:0] lc;
  } vec_t;

  vec_t tbl [0:17];

  int checks   = 0;
  int failures = 0;
  int edgeN    = 0;
  int wsCnt    = 0;
  int rdCnt    = 0;
  int doneCnt  = 0;
  int errCnt   = 0;
  int lastWsEdge  = 0;
  int lastRdEdge  = 0;
  int lastErrEdge = 0;
  int pktEdge  = -1;
  int spcQ[$];

  bit modelOn  = 1'b0;
  int wsAge    = -1;
  int rdAge    = -1;
  int busyLen  = 20;
  int pktLimit = 1000;

  int ws0, rd0, dn0, er0;
  logic found;

  pmu_test_sched #(
    .LOOP_DW(LOOP_DW),
    .GAP_DW (GAP_DW),
    .TMO_DW (TMO_DW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg_loop_num  (cfg_loop_num),
    .cfg_gap_time  (cfg_gap_time),
    .cfg_timeout   (cfg_timeout),
    .sched_start   (sched_start),
    .sched_abort   (sched_abort),
    .pmu_busy      (pmu_busy),
    .packet_done   (packet_done),
    .pmu_work_start(pmu_work_start),
    .pmu_rd_start  (pmu_rd_start),
    .sched_busy    (sched_busy),
    .sched_done    (sched_done),
    .sched_err     (sched_err),
    .err_code      (err_code),
    .loop_cnt      (loop_cnt)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached before the summary");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] outBundle();
    return {9'd0, pmu_work_start, pmu_rd_start, sched_busy, sched_done, sched_err,
            err_code, loop_cnt};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sched_start = v.inp[3];
    sched_abort = v.inp[2];
    pmu_busy    = v.inp[1];
    packet_done = v.inp[0];
  endtask

  // One clock: advance past the edge, record output events, then let the
  // responder model decide the next busy/packet_done levels.
  task automatic tick();
    logic pktWas;
    pktWas = packet_done;
    @(posedge clk);
    #1;
    edgeN++;
    if (pktWas) pktEdge = edgeN;
    if (pmu_work_start) begin
      wsCnt++;
      lastWsEdge = edgeN;
      if (pktEdge >= 0) begin
        spcQ.push_back(edgeN - pktEdge);
        pktEdge = -1;
      end
    end
    if (pmu_rd_start) begin
      rdCnt++;
      lastRdEdge = edgeN;
    end
    if (sched_done) doneCnt++;
    if (sched_err) begin
      errCnt++;
      lastErrEdge = edgeN;
    end
    if (modelOn) begin
      if (pmu_work_start) wsAge = 0;
      else if (wsAge >= 0 && wsAge < 100000) wsAge++;
      if (pmu_rd_start) rdAge = 0;
      else if (rdAge >= 0 && rdAge < 100000) rdAge++;
      pmu_busy    = (wsAge >= 5) && (wsAge < 5 + busyLen);
      packet_done = (rdAge == 8) && (rdCnt <= pktLimit);
    end
  endtask

  task automatic modelReset();
    wsAge       = -1;
    rdAge       = -1;
    pmu_busy    = 1'b0;
    packet_done = 1'b0;
  endtask

  task automatic snap();
    ws0 = wsCnt;
    rd0 = rdCnt;
    dn0 = doneCnt;
    er0 = errCnt;
  endtask

  task automatic startRun(input int loops, input int gap, input int tmo);
    cfg_loop_num = LOOP_DW'(loops);
    cfg_gap_time = GAP_DW'(gap);
    cfg_timeout  = TMO_DW'(tmo);
    sched_start  = 1'b1;
    tick();
    sched_start  = 1'b0;
  endtask

  task automatic runUntilEnd(input int budget, input string name);
    logic ended;
    ended = 1'b0;
    for (int i = 0; i < budget && !ended; i++) begin
      tick();
      if (sched_done || sched_err) ended = 1'b1;
    end
    checkOutput({name, "_finished"}, 32'(ended), 32'd1);
  endtask

  initial begin
    // Per-cycle table: loop_num=2, gap=1, timeout=0.
    tbl[0]  = '{4'b1000, 5'b00100, 2'd0, 16'd0};
    tbl[1]  = '{4'b0000, 5'b10100, 2'd0, 16'd0};
    tbl[2]  = '{4'b0001, 5'b00100, 2'd0, 16'd0};
    tbl[3]  = '{4'b0010, 5'b00100, 2'd0, 16'd0};
    tbl[4]  = '{4'b0010, 5'b00100, 2'd0, 16'd0};
    tbl[5]  = '{4'b0000, 5'b00100, 2'd0, 16'd0};
    tbl[6]  = '{4'b0000, 5'b01100, 2'd0, 16'd0};
    tbl[7]  = '{4'b0001, 5'b00100, 2'd0, 16'd1};
    tbl[8]  = '{4'b0010, 5'b00100, 2'd0, 16'd1};
    tbl[9]  = '{4'b0000, 5'b00100, 2'd0, 16'd1};
    tbl[10] = '{4'b0000, 5'b10100, 2'd0, 16'd1};
    tbl[11] = '{4'b0010, 5'b00100, 2'd0, 16'd1};
    tbl[12] = '{4'b0000, 5'b00100, 2'd0, 16'd1};
    tbl[13] = '{4'b0000, 5'b01100, 2'd0, 16'd1};
    tbl[14] = '{4'b0001, 5'b00100, 2'd0, 16'd2};
    tbl[15] = '{4'b0000, 5'b00010, 2'd0, 16'd2};
    tbl[16] = '{4'b0111, 5'b00000, 2'd0, 16'd2};
    tbl[17] = '{4'b0000, 5'b00000, 2'd0, 16'd2};

    rst_n        = 1'b0;
    cfg_loop_num = '0;
    cfg_gap_time = '0;
    cfg_timeout  = '0;
    sched_start  = 1'b0;
    sched_abort  = 1'b0;
    pmu_busy     = 1'b0;
    packet_done  = 1'b0;
    repeat (3) tick();
    checkOutput("reset_outputs", outBundle(), 32'd0);
    rst_n = 1'b1;
    tick();
    checkOutput("idle_after_reset", outBundle(), 32'd0);

    // Vector table
    cfg_loop_num = 16'd2;
    cfg_gap_time = 16'd1;
    cfg_timeout  = 24'd0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(tbl[i]);
      tick();
      checkOutput($sformatf("vec%0d", i), outBundle(),
                  {9'd0, tbl[i].flg, tbl[i].ec, tbl[i].lc});
    end
    applyStimulus('{4'b0000, 5'b00000, 2'd0, 16'd0});

    // Zero iterations: straight to DONE, no work pulse
    snap();
    startRun(0, 0, 0);
    checkOutput("zero_loop_busy", 32'(sched_busy), 32'd1);
    tick();
    checkOutput("zero_loop_done", 32'(sched_done), 32'd1);
    checkOutput("zero_loop_cnt", 32'(loop_cnt), 32'd0);
    checkOutput("zero_loop_ws", 32'(wsCnt - ws0), 32'd0);

    // Three iterations, gap 10; cfg changes after start must be ignored
    modelOn = 1'b1;
    modelReset();
    busyLen = 20;
    spcQ.delete();
    pktEdge = -1;
    snap();
    startRun(3, 10, 0);
    cfg_loop_num = 16'd1;
    cfg_gap_time = 16'd0;
    runUntilEnd(1000, "run3");
    repeat (5) tick();
    checkOutput("run3_ws", 32'(wsCnt - ws0), 32'd3);
    checkOutput("run3_rd", 32'(rdCnt - rd0), 32'd3);
    checkOutput("run3_done", 32'(doneCnt - dn0), 32'd1);
    checkOutput("run3_err", 32'(errCnt - er0), 32'd0);
    checkOutput("run3_loop_cnt", 32'(loop_cnt), 32'd3);
    checkOutput("run3_gaps", 32'(spcQ.size()), 32'd2);
    checkOutput("run3_spacing0", 32'(spcQ[0]), 32'd12);
    checkOutput("run3_spacing1", 32'(spcQ[1]), 32'd12);

    // Busy never rises: timeout 50 in WAIT_BH
    modelReset();
    busyLen = 0;
    snap();
    startRun(2, 0, 50);
    runUntilEnd(300, "tmo_bh");
    checkOutput("tmo_bh_err", 32'(errCnt - er0), 32'd1);
    checkOutput("tmo_bh_latency", 32'(lastErrEdge - lastWsEdge), 32'd50);
    checkOutput("tmo_bh_code", 32'(err_code), 32'd1);
    checkOutput("tmo_bh_loop_cnt", 32'(loop_cnt), 32'd0);
    checkOutput("tmo_bh_rd", 32'(rdCnt - rd0), 32'd0);
    checkOutput("tmo_bh_idle", 32'(sched_busy), 32'd0);

    // Busy falls exactly at timer 99 (exit wins); packet withheld on iteration 2
    modelReset();
    busyLen  = 100;
    pktLimit = rdCnt + 1;
    snap();
    startRun(4, 3, 100);
    runUntilEnd(2000, "tmo_pkt");
    checkOutput("tmo_pkt_err", 32'(errCnt - er0), 32'd1);
    checkOutput("tmo_pkt_code", 32'(err_code), 32'd3);
    checkOutput("tmo_pkt_loop_cnt", 32'(loop_cnt), 32'd1);
    checkOutput("tmo_pkt_rd", 32'(rdCnt - rd0), 32'd2);
    checkOutput("tmo_pkt_latency", 32'(lastErrEdge - lastRdEdge), 32'd100);
    checkOutput("tmo_pkt_done", 32'(doneCnt - dn0), 32'd0);
    pktLimit = 1000;

    // Abort during the first gap; a start while busy is ignored
    modelReset();
    busyLen = 20;
    pktEdge = -1;
    snap();
    startRun(5, 20, 0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (pktEdge >= 0) found = 1'b1;
    end
    checkOutput("abort_reached_gap", 32'(found), 32'd1);
    repeat (2) tick();
    cfg_loop_num = 16'd1;
    sched_start  = 1'b1;
    tick();
    sched_start  = 1'b0;
    checkOutput("busy_start_ignored", {15'd0, sched_busy, loop_cnt}, {15'd0, 1'b1, 16'd1});
    tick();
    sched_abort = 1'b1;
    tick();
    sched_abort = 1'b0;
    checkOutput("abort_err", {29'd0, sched_err, err_code}, {29'd0, 1'b1, 2'd0});
    checkOutput("abort_state", {15'd0, sched_busy, loop_cnt}, {15'd0, 1'b0, 16'd1});
    ws0 = wsCnt;
    repeat (40) tick();
    checkOutput("abort_no_ws", 32'(wsCnt - ws0), 32'd0);

    // Start and abort together in IDLE: start wins, run completes cleanly
    snap();
    cfg_loop_num = 16'd1;
    cfg_gap_time = 16'd0;
    cfg_timeout  = 24'd0;
    sched_start  = 1'b1;
    sched_abort  = 1'b1;
    tick();
    sched_start  = 1'b0;
    sched_abort  = 1'b0;
    checkOutput("start_abort_idle", {13'd0, sched_busy, sched_err, err_code, loop_cnt},
                {13'd0, 1'b1, 1'b0, 2'd0, 16'd0});
    runUntilEnd(500, "rerun");
    checkOutput("rerun_done", 32'(doneCnt - dn0), 32'd1);
    checkOutput("rerun_err", 32'(errCnt - er0), 32'd0);
    checkOutput("rerun_loop_cnt", 32'(loop_cnt), 32'd1);

    // Asynchronous reset while rd_start is high, then a clean 2-iteration run
    modelReset();
    startRun(2, 2, 0);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      tick();
      if (pmu_rd_start) found = 1'b1;
    end
    checkOutput("reset_reached_read", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_outputs", outBundle(), 32'd0);
    modelReset();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checkOutput("post_reset_idle", outBundle(), 32'd0);
    snap();
    startRun(2, 2, 0);
    runUntilEnd(500, "post_reset_run");
    checkOutput("post_reset_ws", 32'(wsCnt - ws0), 32'd2);
    checkOutput("post_reset_rd", 32'(rdCnt - rd0), 32'd2);
    checkOutput("post_reset_done", 32'(doneCnt - dn0), 32'd1);
    checkOutput("post_reset_err", 32'(errCnt - er0), 32'd0);
    checkOutput("post_reset_loop_cnt", 32'(loop_cnt), 32'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
